// File: rtl/bus_rr_scheduler.sv
// bus_rr_scheduler: round-robin scheduler for one shared broadcast bus.
//
// Grants one pending device FIFO at a time, pops its head word, decodes the
// 8-bit destination ID in the word's top byte, and pushes the word to the
// addressed device or, on broadcast, to every device except the source.
//
// Optional feature: define BUS_RR_LOOPBACK_EN to deliver a unicast whose ID
// equals the source device back to that device. Without it such a packet is
// dropped.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high reset
//   pndng     per-device FIFO non-empty flags (show-ahead head on D_pop)
//   D_pop     per-device FIFO head words
//   pop       one-hot, one-cycle dequeue strobe to the granted device
//   push      enqueue strobes to the destination devices
//   D_push    shared bus data
//   grant_id  index of the current or last granted device
//   busy      high while granting or pushing
//   drop      one-cycle pulse when a popped packet is discarded
module bus_rr_scheduler #(
    parameter int unsigned drvrs     = 5,
    parameter int unsigned pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'b1000_1111
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [drvrs-1:0]                 pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]    D_pop,
    output logic [drvrs-1:0]                 pop,
    output logic [drvrs-1:0]                 push,
    output logic [pckg_sz-1:0]               D_push,
    output logic [$clog2(drvrs)-1:0]         grant_id,
    output logic                             busy,
    output logic                             drop
);

    localparam int unsigned IdW = $clog2(drvrs);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StPush
    } state_e;

    state_e             state_q, state_d;
    logic [IdW-1:0]     last_q, last_d;
    logic [IdW-1:0]     grant_q, grant_d;
    logic [pckg_sz-1:0] data_q, data_d;

    logic [IdW-1:0]     winner;
    logic [IdW-1:0]     cand;
    logic               found;

    logic [7:0]         dest_id;
    logic               dest_valid;
    logic [drvrs-1:0]   src_onehot;
    logic [drvrs-1:0]   dest_mask;
    logic               dest_drop;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        winner = last_q;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= drvrs; k++) begin
            cand = IdW'((32'(last_q) + k) % drvrs);
            if (!found && pndng[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Destination decode from the registered packet and registered source.
    always_comb begin
        dest_id    = data_q[pckg_sz-1 -: 8];
        dest_valid = (32'(dest_id) < drvrs);
        src_onehot = drvrs'(1) << grant_q;
        dest_mask  = '0;
        dest_drop  = 1'b0;
        if (dest_id == broadcast) begin
            dest_mask = ~src_onehot;
        end else if (dest_valid && (dest_id[IdW-1:0] == grant_q)) begin
`ifdef BUS_RR_LOOPBACK_EN
            dest_mask = src_onehot;
`else
            dest_drop = 1'b1;
`endif
        end else if (dest_valid) begin
            dest_mask = drvrs'(1) << dest_id[IdW-1:0];
        end else begin
            dest_drop = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle, StPush: begin
                if (|pndng) begin
                    state_d = StGrant;
                    grant_d = winner;
                    last_d  = winner;
                end else begin
                    state_d = StIdle;
                end
            end
            StGrant: begin
                data_d  = D_pop[grant_q];
                state_d = StPush;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= IdW'(drvrs - 1);
            grant_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            data_q  <= data_d;
        end
    end

    // data_q only changes at the end of GRANT, so it doubles as the held bus value.
    always_comb begin
        pop      = (state_q == StGrant) ? src_onehot : '0;
        push     = (state_q == StPush) ? dest_mask : '0;
        drop     = (state_q == StPush) && dest_drop;
        D_push   = data_q;
        grant_id = grant_q;
        busy     = (state_q != StIdle);
    end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
module tb_bus_rr_scheduler;

    localparam int D = 5;
    localparam int W = 16;
    localparam int GW = $clog2(D);
    localparam int BCAST = 143;

    localparam int KIdle  = 0;
    localparam int KGrant = 1;
    localparam int KPush  = 2;

    typedef struct {
        logic [D-1:0] mask;
        logic         drop;
        logic [W-1:0] data;
    } exp_t;

    logic                clk;
    logic                reset;
    logic [D-1:0]        pndng;
    logic [D-1:0][W-1:0] d_pop;
    logic [D-1:0]        pop;
    logic [D-1:0]        push;
    logic [W-1:0]        d_push;
    logic [GW-1:0]       grant_id;
    logic                busy;
    logic                drop;

    bus_rr_scheduler #(
        .drvrs     (D),
        .pckg_sz   (W),
        .broadcast (8'h8F)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push),
        .grant_id (grant_id),
        .busy     (busy),
        .drop     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device FIFOs as seen by the scheduler, plus the reference state.
    logic [W-1:0] fifo [D][$];
    exp_t         sbq[$];
    int           n_checks = 0;
    int           n_pass = 0;
    int           push_count = 0;
    int           model_last = D - 1;
    int           exp_kind = KIdle;
    logic [D-1:0] prev_pndng = '0;
    logic         pend_valid = 1'b0;
    int           pend_src = 0;
    logic         reset_at_edge = 1'b0;

    always @(posedge clk) reset_at_edge <= reset;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    endtask

    // Round-robin pick: first pending device after the previous winner.
    function automatic int rr_pick(input logic [D-1:0] p, input int last);
        logic [D-1:0] sh;
        for (int k = 1; k <= D; k++) begin
            int idx = (last + k) % D;
            sh = p >> idx;
            if (sh[0]) return idx;
        end
        return -1;
    endfunction

    function automatic exp_t expect_resp(input int src, input logic [W-1:0] w);
        exp_t e;
        int id = int'(w[W-1 -: 8]);
        e.data = w;
        e.mask = '0;
        e.drop = 1'b0;
        if (id == BCAST) begin
            e.mask = ~(D'(1) << src);
        end else if (id == src) begin
`ifdef BUS_RR_LOOPBACK_EN
            e.mask = D'(1) << src;
`else
            e.drop = 1'b1;
`endif
        end else if (id < D) begin
            e.mask = D'(1) << id;
        end else begin
            e.drop = 1'b1;
        end
        return e;
    endfunction

    // Monitor and model: runs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [W-1:0] tmp;
        logic [D-1:0] np;
        exp_t         e;
        int           w;
        // A FIFO dequeues on the edge that ends its GRANT cycle.
        if (pend_valid) begin
            if (fifo[pend_src].size() != 0) tmp = fifo[pend_src].pop_front();
            pend_valid = 1'b0;
        end
        if (reset_at_edge) begin
            sbq.delete();
            model_last = D - 1;
            exp_kind = KIdle;
            check("reset_outputs", 32'({pop, push, d_push, grant_id, busy, drop}), 32'd0);
        end
        check("busy", 32'(busy), 32'(exp_kind != KIdle));
        if (exp_kind == KGrant) begin
            w = rr_pick(prev_pndng, model_last);
            if (w >= 0) begin
                check("pop_winner", 32'(pop), 32'(D'(1) << w));
                check("grant_id", 32'(grant_id), 32'(w));
                model_last = w;
                sbq.push_back(expect_resp(w, fifo[w][0]));
                pend_valid = 1'b1;
                pend_src = w;
            end
        end else begin
            check("pop_idle", 32'(pop), 32'd0);
        end
        if (exp_kind == KPush) begin
            check("sb_item_avail", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("push_drop_data", 32'({drop, push, d_push}), 32'({e.drop, e.mask, e.data}));
            end
        end else begin
            check("no_push", 32'({drop, push}), 32'd0);
        end
        if (push != '0) push_count++;
        for (int i = 0; i < D; i++) begin
            np[i] = (fifo[i].size() != 0);
            d_pop[i] = np[i] ? fifo[i][0] : '0;
        end
        pndng = np;
        exp_kind = (exp_kind == KGrant) ? KPush : ((np != '0) ? KGrant : KIdle);
        prev_pndng = np;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        logic done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            step();
            done = !busy && !pend_valid;
            for (int i = 0; i < D; i++) if (fifo[i].size() != 0) done = 1'b0;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        int c0;
        int src;
        logic got;
        logic [7:0] id;
        reset = 1'b1;
        pndng = '0;
        d_pop = '0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Unicast, broadcast, invalid and self destinations.
        fifo[1].push_back(16'h0312);
        wait_idle("unicast_done");
        fifo[2].push_back(16'h8FAA);
        wait_idle("bcast_done");
        fifo[0].push_back(16'h0755);
        wait_idle("invalid_done");
        fifo[0].push_back(16'h0066);
        wait_idle("self_done");

        // Fairness: all devices loaded with three words each.
        c0 = push_count;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < D; i++)
                fifo[i].push_back({8'((i + 1) % D), 8'(16 * r + i)});
        wait_idle("fair_done");
        check("fair_push_count", 32'(push_count - c0), 32'd15);

        // Reset during GRANT: the popped word is lost, device 0 wins afterwards.
        fifo[3].push_back(16'h0133);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            got = (pop != '0);
        end
        check("midreset_grant_seen", 32'(got), 32'd1);
        reset = 1'b1;
        fifo[0].push_back(16'h0201);
        fifo[1].push_back(16'h0002);
        step();
        reset = 1'b0;
        wait_idle("midreset_done");

        // Randomized traffic with mixed destinations.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                src = int'($urandom_range(0, D - 1));
                case ($urandom_range(0, 9))
                    0: id = 8'h8F;
                    1: id = 8'($urandom_range(5, 142));
                    2: id = 8'(src);
                    default: id = 8'($urandom_range(0, D - 1));
                endcase
                if (fifo[src].size() < 4) fifo[src].push_back({id, 8'($urandom)});
            end
            step();
        end
        wait_idle("random_drain");
        check("sb_empty_end", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
